// File: rtl/seq_divider.sv
// Sequential radix-2 restoring unsigned divider with valid/ready handshakes.
// Produces one quotient bit per clock; a zero divisor completes immediately.
module seq_divider #(
   parameter int DW = 64,
   parameter int VW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
);

   localparam int CW = $clog2(DW + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_next;
   logic [DW-1:0] dvd_q;
   logic [VW:0]   prem_q;
   logic [VW-1:0] dsr_q;
   logic [CW-1:0] cnt_q;

   logic [VW+1:0] shifted;
   logic [VW+1:0] dsr_ext;
   logic [VW:0]   prem_next;
   logic          qbit;
   logic          last_step;

   // One restoring step: shift {remainder, dividend} left, trial-subtract the divisor.
   always_comb begin
      shifted   = {prem_q, dvd_q[DW-1]};
      dsr_ext   = {2'b00, dsr_q};
      qbit      = (shifted >= dsr_ext);
      prem_next = qbit ? (VW+1)'(shifted - dsr_ext) : shifted[VW:0];
      last_step = (cnt_q == CW'(DW - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = (divisor == '0) ? DONE : RUN;
         end
         RUN: begin
            if (last_step) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd_q       <= '0;
         prem_q      <= '0;
         dsr_q       <= '0;
         cnt_q       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (divisor != '0) begin
                     dvd_q  <= dividend;
                     prem_q <= '0;
                     dsr_q  <= divisor;
                     cnt_q  <= '0;
                  end else begin
                     quotient    <= '1;
                     remainder   <= dividend[VW-1:0];
                     div_by_zero <= 1'b1;
                  end
               end
            end
            RUN: begin
               dvd_q  <= {dvd_q[DW-2:0], qbit};
               prem_q <= prem_next;
               cnt_q  <= cnt_q + 1'b1;
               if (last_step) begin
                  quotient    <= {dvd_q[DW-2:0], qbit};
                  remainder   <= prem_next[VW-1:0];
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential radix-2 restoring unsigned divider; the inverse of the 32x32->64 karatsuba_mac multiplier.
- Takes a 64-bit dividend and a 32-bit divisor and returns a 64-bit quotient and 32-bit remainder.
- Used to check multiplier products in-system and for normalisation in the LDMM accelerator datapath.
- Uses valid/ready handshakes on input and output, with one quotient bit produced per clock.

Parameters:
- DW, 64, dividend and quotient width in bits.
- VW, 32, divisor and remainder width in bits. VW must be less than or equal to DW.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  dividend and divisor are valid
- in_ready  output  1  block can accept an operation
- dividend  input  DW  unsigned dividend
- divisor  input  VW  unsigned divisor
- out_valid  output  1  quotient, remainder and div_by_zero are valid
- out_ready  input  1  consumer accepts the result
- quotient  output  DW  unsigned quotient
- remainder  output  VW  unsigned remainder
- div_by_zero  output  1  result is from a zero divisor

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE.
  - in_ready=1 while in IDLE; out_valid=0.
  - quotient, remainder and div_by_zero are cleared to 0.
  - An operation in progress is discarded with no output.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE). No input is accepted in RUN or DONE.
- Accept: in_valid & in_ready at a rising edge captures dividend and divisor.
  - Changes on the inputs after that edge are ignored.
  - divisor!=0: go to RUN. Load the shift register with the dividend and clear the partial remainder (VW+1 bits) and the iteration counter.
  - divisor==0: go straight to DONE with quotient = all ones, remainder = dividend[VW-1:0], div_by_zero=1.
- RUN: each clock performs one restoring step.
  - Shift {partial remainder, dividend register} left by one.
  - Trial-subtract the divisor from the (VW+1)-bit partial remainder.
  - Non-negative result: keep the difference and shift in quotient bit 1. Otherwise restore and shift in 0.
  - After exactly DW steps, go to DONE. quotient holds the DW-bit result, remainder = partial remainder[VW-1:0], div_by_zero=0.
- Latency:
  - divisor!=0: out_valid rises DW cycles after the accepting edge (64 cycles by default).
  - divisor==0: out_valid rises 1 cycle after the accepting edge.
- DONE: out_valid=1 and all result outputs are held stable until out_valid & out_ready at an edge.
  - On that handshake: go to IDLE, in_ready=1 the next cycle, out_valid=0.
  - Result registers keep their last value until the next operation completes.
- Throughput: at most one operation per DW+2 cycles. There is no bypass from DONE to RUN.
- Invariant: for divisor!=0, dividend == quotient*divisor + remainder and remainder < divisor (full-width arithmetic).
- Boundary cases:
  - dividend < divisor: quotient 0, remainder = dividend.
  - divisor = 1: quotient = dividend, remainder 0.
  - dividend = 0: quotient 0, remainder 0, full DW-cycle latency.
- Counter: ceil(log2(DW+1)) bits, no wrap.
- in_valid held high while busy does not restart or corrupt the operation in progress.

Test Plan:
- dividend 1082152022374638 (12345678*87654321), divisor 87654321 -> after 64 cycles quotient 12345678, remainder 0, div_by_zero 0.
- dividend 246913575308647, divisor 22222222 -> quotient 11111111, remainder 5.
- dividend 2^64-1, divisor 1 -> quotient 2^64-1, remainder 0. Then dividend 2^64-1, divisor 2^32-1 -> quotient 0x0000000100000001, remainder 0.
- dividend 7, divisor 9 -> quotient 0, remainder 7. Then divisor 0 with dividend 0x1_DEADBEEF -> out_valid after 1 cycle, quotient all ones, remainder 0xDEADBEEF, div_by_zero 1.
- Back-pressure: out_ready=0 for 10 cycles after out_valid -> outputs stable and in_ready=0 throughout. out_ready=1 -> IDLE next cycle. A second operation queued on in_valid is then accepted and correct.
- Reset mid-RUN: deassert rst_n at step 30 -> immediately in_ready=1, out_valid=0, outputs 0. A new operation after release completes correctly in 64 cycles.
